// File: rtl/pattern_collector.sv
// pattern_collector: gathers pixels from a bank of row-interleaved pattern
// solvers, rebuilds each pixel's frame-buffer address, buffers pixels per
// solver and feeds a single back-pressured frame-buffer write port.
module pattern_collector #(
  parameter int NUM_SOLVERS = 4,
  parameter int NUM_COLUMNS = 640,
  parameter int NUM_ROWS    = 480,
  parameter int FIFO_DEPTH  = 8,
  parameter int ADDR_W      = 19
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [4*NUM_SOLVERS-1:0] solver_out,
  input  logic [NUM_SOLVERS-1:0]   solver_ready,
  input  logic [NUM_SOLVERS-1:0]   solver_done,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [3:0]               wr_data,
  input  logic                     mem_ready,
  output logic                     frame_done,
  output logic                     overflow,
  output logic                     busy
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int COL_W   = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;
  localparam int SOL_W   = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;
  localparam int ENTRY_W = ADDR_W + 4;

  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(NUM_COLUMNS - 1);
  localparam logic [ADDR_W-1:0] ROW_SKIP  = ADDR_W'((NUM_SOLVERS - 1) * NUM_COLUMNS + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [SOL_W-1:0]  LAST_SOL  = SOL_W'(NUM_SOLVERS - 1);

  // Rows are dealt out to solvers in strict rotation, so the frame height
  // has to divide evenly among them.
  if ((NUM_ROWS % NUM_SOLVERS) != 0) begin : g_rows_check
    $error("NUM_ROWS must be a multiple of NUM_SOLVERS");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [COL_W-1:0]   col      [NUM_SOLVERS];
  logic [ADDR_W-1:0]  addr     [NUM_SOLVERS];
  logic [ENTRY_W-1:0] fifo_mem [NUM_SOLVERS][FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr   [NUM_SOLVERS];
  logic [PTR_W-1:0]   rd_ptr   [NUM_SOLVERS];
  logic [CNT_W-1:0]   count    [NUM_SOLVERS];

  logic [NUM_SOLVERS-1:0] fifo_empty;
  logic [NUM_SOLVERS-1:0] fifo_full;
  logic [NUM_SOLVERS-1:0] push_req;
  logic [NUM_SOLVERS-1:0] push_ok;
  logic [NUM_SOLVERS-1:0] pop;

  logic [SOL_W-1:0]   rr_ptr;
  logic [SOL_W-1:0]   grant_idx;
  logic               grant_valid;
  logic               grant_fire;
  logic               slot_free;
  logic               transfer;
  logic               drop;
  logic               all_empty;
  logic [ENTRY_W-1:0] grant_entry;

  assign transfer    = wr_en && mem_ready;
  assign slot_free   = !wr_en || mem_ready;
  assign grant_fire  = grant_valid && slot_free && !start;
  assign grant_entry = fifo_mem[grant_idx][rd_ptr[grant_idx]];
  assign drop        = |(push_req & ~push_ok);
  assign all_empty   = &fifo_empty;

  // Per-FIFO status; a full FIFO still accepts a push when it is popped in the same cycle.
  always_comb begin
    fifo_empty = '0;
    fifo_full  = '0;
    push_req   = '0;
    push_ok    = '0;
    pop        = '0;
    for (int i = 0; i < NUM_SOLVERS; i++) begin
      fifo_empty[i] = (count[i] == '0);
      fifo_full[i]  = (count[i] == FULL_CNT);
      pop[i]        = grant_fire && (grant_idx == SOL_W'(i));
      push_req[i]   = (state == RUN) && solver_ready[i] && !start;
      push_ok[i]    = push_req[i] && (!fifo_full[i] || pop[i]);
    end
  end

  // Round-robin search over non-empty FIFOs beginning at rr_ptr.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_SOLVERS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_SOLVERS) begin
        idx = idx - NUM_SOLVERS;
      end
      if (!grant_valid && !fifo_empty[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = SOL_W'(idx);
      end
    end
  end

  // FIFO storage holds {address, pixel}; contents need no reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SOLVERS; i++) begin
      if (push_ok[i]) begin
        fifo_mem[i][wr_ptr[i]] <= {addr[i], solver_out[4*i +: 4]};
      end
    end
  end

  // FIFO pointers and occupancy; start flushes every FIFO.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SOLVERS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else if (start) begin
      for (int i = 0; i < NUM_SOLVERS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SOLVERS; i++) begin
        if (push_ok[i]) begin
          wr_ptr[i] <= wr_ptr[i] + 1'b1;
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + 1'b1;
        end
        count[i] <= count[i] + CNT_W'(push_ok[i]) - CNT_W'(pop[i]);
      end
    end
  end

  // Address trackers walk each solver's rows, skipping the rows owned by the others.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SOLVERS; i++) begin
        col[i]  <= '0;
        addr[i] <= ADDR_W'(i * NUM_COLUMNS);
      end
    end else if (start) begin
      for (int i = 0; i < NUM_SOLVERS; i++) begin
        col[i]  <= '0;
        addr[i] <= ADDR_W'(i * NUM_COLUMNS);
      end
    end else if (state == RUN) begin
      for (int i = 0; i < NUM_SOLVERS; i++) begin
        if (solver_ready[i]) begin
          if (col[i] != LAST_COL) begin
            col[i]  <= col[i] + 1'b1;
            addr[i] <= addr[i] + 1'b1;
          end else begin
            col[i]  <= '0;
            addr[i] <= addr[i] + ROW_SKIP;
          end
        end
      end
    end
  end

  // Output slot reloads in the same cycle it transfers, so writes can stream back to back.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (start) begin
      wr_en <= 1'b0;
    end else if (grant_fire) begin
      wr_en   <= 1'b1;
      wr_addr <= grant_entry[ENTRY_W-1:4];
      wr_data <= grant_entry[3:0];
    end else if (transfer) begin
      wr_en <= 1'b0;
    end
  end

  // Round-robin pointer moves to the solver after the one just granted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (start) begin
      rr_ptr <= '0;
    end else if (grant_fire) begin
      rr_ptr <= (grant_idx == LAST_SOL) ? '0 : grant_idx + 1'b1;
    end
  end

  // Sticky record of any pixel lost to a full FIFO.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (start) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  // Frame state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Frame sequencing and status outputs; start always restarts into RUN.
  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    busy       = 1'b0;
    if (start) begin
      state_next = RUN;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        RUN:     if (&solver_done) state_next = DRAIN;
        DRAIN:   if (all_empty && !wr_en) state_next = DONE;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
    case (state)
      RUN, DRAIN: busy       = 1'b1;
      DONE:       frame_done = 1'b1;
      default:    busy       = 1'b0;
    endcase
  end

endmodule
